// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Idle line is high; bytes are sent LSB first, back-to-back frames are 10*CLKS_PER_BIT+1 apart.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 21000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [15:0]      BAUD_MAX = 16'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_d;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [7:0]        shreg, shreg_d;
   logic [15:0]       baud_cnt, baud_d;
   logic [2:0]        bit_cnt, bit_d;
   logic              txd_d;
   logic              push, pop, tick;

   // Handshake and pop decisions use only registered state and count
   assign tx_ready = (fifo_count != FULL);
   assign push     = tx_valid && tx_ready;
   assign pop      = (state == IDLE) && (fifo_count != '0);
   assign tick     = (baud_cnt == BAUD_MAX);
   assign tx_busy  = (state != IDLE) || (fifo_count != '0);

   // FIFO storage; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Serialiser state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         shreg    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_d;
         shreg    <= shreg_d;
         baud_cnt <= baud_d;
         bit_cnt  <= bit_d;
         txd      <= txd_d;
      end
   end

   // Next-state and next line value
   always_comb begin
      state_d = state;
      shreg_d = shreg;
      baud_d  = baud_cnt;
      bit_d   = bit_cnt;
      txd_d   = txd;
      if (state != IDLE) baud_d = tick ? 16'd0 : baud_cnt + 16'd1;
      case (state)
         IDLE: begin
            txd_d  = 1'b1;
            baud_d = '0;
            if (pop) begin
               shreg_d = mem[rd_ptr];
               txd_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               txd_d   = shreg[0];
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_cnt + 3'd1;
                  txd_d = shreg[1];
               end
            end
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=16: handshake driver, line-decoding monitor, byte scoreboard.
module tb_uart_tx;

   localparam int C     = 16;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, txd, tx_busy;
   logic [2:0] fifo_count;

   int tests = 0, fails = 0, cyc = 0;
   logic [7:0] sb[$];
   int         falls[$];

   bit         m_act = 1'b0;
   bit         m_glitch;
   int         m_cnt;
   logic [9:0] m_bits;
   logic [7:0] exp_b;

   typedef struct {
      logic [7:0] data;
      int         cnt;
      int         rdy;
   } vec_t;
   vec_t fill_v[5];
   int   line_exp[10];

   uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Decode frames from the line; every cycle of a bit must hold that bit's level
   always @(negedge clk) begin
      if (!n_rst) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (txd === 1'b0) begin
            m_act = 1'b1; m_cnt = 0; m_glitch = 1'b0; m_bits = '0;
            falls.push_back(cyc);
         end
      end else begin
         m_cnt++;
         if (m_cnt % C == 0) m_bits[4'(m_cnt / C)] = txd;
         else if (txd !== m_bits[4'(m_cnt / C)]) m_glitch = 1'b1;
         if (m_cnt == FRAME - 1) begin
            m_act = 1'b0;
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL frame: got unexpected byte %02h, required no frame", m_bits[8:1]);
            end else begin
               exp_b = sb.pop_front();
               if (m_bits[8:1] !== exp_b || m_bits[9] !== 1'b1 || m_glitch) begin
                  fails++;
                  $display("FAIL frame: got data %02h stop %0b glitch %0b, required data %02h stop 1 glitch 0",
                           m_bits[8:1], m_bits[9], m_glitch, exp_b);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [7:0] d, output int acc);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         chk("accept timeout", 0, 1);
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         sb.push_back(d);
         @(negedge clk);
      end
   endtask

   task automatic wait_until(input int t);
      int n = 0;
      while (cyc < t && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || m_act || tx_busy) && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain complete", int'(sb.size() == 0 && !tx_busy), 1);
   endtask

   initial begin
      int acc, e1, f, nf, n;

      fill_v[0] = '{8'h00, 1, 1};
      fill_v[1] = '{8'hFF, 1, 1};
      fill_v[2] = '{8'h55, 2, 1};
      fill_v[3] = '{8'h3C, 3, 1};
      fill_v[4] = '{8'h81, 4, 0};
      line_exp  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      // Reset state and quiet line
      repeat (3) @(negedge clk);
      chk("reset txd", int'(txd), 1);
      chk("reset tx_ready", int'(tx_ready), 1);
      chk("reset tx_busy", int'(tx_busy), 0);
      chk("reset fifo_count", int'(fifo_count), 0);
      n_rst = 1'b1;
      repeat (1000) @(negedge clk);
      chk("idle no frames", falls.size(), 0);
      chk("idle txd", int'(txd), 1);

      // Single byte: latency, line levels, busy drop
      send(8'hA5, acc);
      tx_valid = 1'b0;
      n = 0;
      while (falls.size() == 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("single fall seen", int'(falls.size() == 1), 1);
      f = (falls.size() > 0) ? falls[0] : acc + 1;
      chk("first frame latency", f - acc, 1);
      for (int k = 0; k < 10; k++) begin
         wait_until(f + C / 2 + C * k);
         chk($sformatf("line bit %0d", k), int'(txd), line_exp[k]);
      end
      wait_until(f + FRAME - 1);
      chk("busy in stop", int'(tx_busy), 1);
      wait_until(f + FRAME);
      chk("busy dropped", int'(tx_busy), 0);
      drain();

      // FIFO fill with held valid; sixth byte waits for a pop
      falls.delete();
      e1 = 0;
      for (int i = 0; i < 5; i++) begin
         send(fill_v[i].data, acc);
         if (i == 0) e1 = acc;
         chk($sformatf("fill accept edge %0d", i), acc - e1, i);
         chk($sformatf("fill count %0d", i), int'(fifo_count), fill_v[i].cnt);
         chk($sformatf("fill ready %0d", i), int'(tx_ready), fill_v[i].rdy);
      end
      send(8'h7E, acc);
      tx_valid = 1'b0;
      chk("sixth accept edge", acc - e1, 163);
      drain();
      chk("fill frame count", falls.size(), 6);
      if (falls.size() == 6) begin
         chk("fill first fall", falls[0] - e1, 1);
         for (int i = 1; i < 6; i++)
            chk($sformatf("frame spacing %0d", i), falls[i] - falls[i-1], FRAME + 1);
      end

      // Stall: 0xC3 held while full is accepted once
      falls.delete();
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h11 * (i + 1)), acc);
         if (i == 0) e1 = acc;
      end
      chk("stall full ready", int'(tx_ready), 0);
      send(8'hC3, acc);
      tx_valid = 1'b0;
      chk("stall accept edge", acc - e1, 163);
      chk("stall count after", int'(fifo_count), 4);
      chk("stall ready dips", int'(tx_ready), 0);
      drain();
      chk("stall frame count", falls.size(), 6);

      // Reset during DATA bit 3 with two bytes buffered
      falls.delete();
      send(8'h01, acc);
      e1 = acc;
      send(8'h02, acc);
      send(8'h03, acc);
      tx_valid = 1'b0;
      chk("midreset buffered", int'(fifo_count), 2);
      wait_until(e1 + 1 + 4 * C + 6);
      #2;
      n_rst = 1'b0;
      #1;
      chk("midreset txd", int'(txd), 1);
      chk("midreset count", int'(fifo_count), 0);
      chk("midreset ready", int'(tx_ready), 1);
      chk("midreset busy", int'(tx_busy), 0);
      sb.delete();
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      nf = falls.size();
      repeat (400) @(negedge clk);
      chk("post reset no frame", falls.size(), nf);
      chk("post reset txd", int'(txd), 1);
      chk("post reset busy", int'(tx_busy), 0);

      chk("scoreboard empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter with input byte FIFO: the stage directly upstream of the `rx` receiver. It accepts bytes over a valid/ready handshake, buffers them, and serialises each as an 8N1 frame on `txd`, LSB first. `txd` drives the `rxd` input of the receiver, either on-chip for loopback or through the board serial line.

## Interface
- `CLKS_PER_BIT`, 21000: clk cycles per serial bit; must match the receiver's bit period; legal range 4..65535.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `tx_data`  in  8: byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1: producer holds a valid byte.
- `tx_ready`  out  1: FIFO can accept; equals `fifo_count != FIFO_DEPTH`.
- `txd`  out  1: serial line, registered output, idle high.
- `tx_busy`  out  1: high when the serialiser is not in IDLE or `fifo_count != 0`.
- `fifo_count`  out  log2(FIFO_DEPTH)+1: bytes currently buffered, registered.

## Operation
- **FIFO.**
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap naturally.
  - Push on `tx_valid && tx_ready`.
  - Pop when the FSM is in IDLE and `fifo_count != 0`.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - `tx_ready` is derived from the registered count only. A push is never accepted while full, even in the cycle of a pop.
  - A pop never occurs when empty, even if a push arrives in that cycle.
- **FSM states:** IDLE, START, DATA, STOP (2-bit encoding).
  - IDLE: `txd`=1. If `fifo_count != 0`, pop the head into an 8-bit shift register, clear the baud counter, set `txd`<=0 and go to START.
  - START: on baud tick, go to DATA, with `txd`<=shreg[0] and bit counter cleared.
  - DATA: on baud tick, shift shreg right and increment the bit counter. Drive the next bit on `txd`. After bit 7's tick, `txd`<=1 and go to STOP.
  - STOP: on baud tick, go to IDLE.
- **Baud counter.**
  - 16-bit, counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - A tick occurs when the counter equals CLKS_PER_BIT-1; it then wraps to 0.
  - The counter is held at 0 in IDLE.
- **Bit counter.** 3-bit, 0..7, active only in DATA.
- **Reset.** Asynchronous assertion at any time, including mid-frame:
  - state IDLE, `txd`=1, pointers and `fifo_count`=0, `tx_ready`=1, `tx_busy`=0, shreg=0x00, counters 0.
  - Buffered bytes are discarded.
  - Deassertion takes effect on the next rising clk edge.

## Timing
- **First frame latency.** A byte accepted at edge N with the FSM idle and the FIFO empty is popped at edge N+1. `txd` falls after edge N+1.
- **Frame length.** Each bit lasts exactly CLKS_PER_BIT cycles. One frame is 10*CLKS_PER_BIT cycles from start-bit fall to the end of the stop bit.
- **Back-to-back frames.** With a non-empty FIFO, IDLE lasts exactly 1 cycle. Each stop bit is therefore followed by 1 extra high cycle, and frame-to-frame spacing is 10*CLKS_PER_BIT+1 cycles.
- **Count update.** `fifo_count` and `tx_ready` change on the edge after a push or pop. `tx_busy` follows the registered state and count.
- **Stalled handshake.** While `tx_valid`=1 and `tx_ready`=0, the producer holds `tx_data` stable. No partial accept occurs.

## Test plan
- **Reset:** assert `n_rst` for 3 cycles -> `txd`=1, `tx_ready`=1, `tx_busy`=0, `fifo_count`=0. With no `tx_valid`, `txd` stays 1 for 1000 cycles.
- **Single byte (CLKS_PER_BIT=16):** push 0xA5 at edge N -> `txd` falls after N+1. Line sequence per 16 cycles is 0,1,0,1,0,0,1,0,1,1. `tx_busy` drops 160 cycles after the fall.
- **FIFO fill (CLKS_PER_BIT=16, depth 4):** hold `tx_valid` for 6 bytes 0x00,0xFF,0x55,0x3C,0x81,0x7E.
  - `fifo_count` after each edge is 1,1,2,3,4; `tx_ready` then goes low.
  - The 6th byte is accepted 1 cycle after the next pop.
  - All six frames arrive in order, 161 cycles apart.
- **Reset mid-frame:** assert `n_rst` during DATA bit 3 with 2 bytes buffered -> `txd`=1 immediately, `fifo_count`=0. After release, no frame is emitted.
- **Stall:** `tx_valid`=1 while full with `tx_data`=0xC3 held -> the byte is accepted on exactly one edge, `tx_ready` dips accordingly, and 0xC3 is sent once.
- **Loopback into rx (defaults, CLKS_PER_BIT=21000):** push 0x3C then 0xA5 -> `rx_data`=0x3C after the first frame and 0xA5 after the second.
